// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-access slave.
package i2c_pkg;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h3C;
  localparam int         BITCNT_W     = 4;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    REGH,
    REGH_ACK,
    REGL,
    REGL_ACK,
    WDAT,
    WDAT_ACK,
    RDAT,
    RDAT_ACK,
    IGNORE
  } state_e;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-FF synchronizers, optional 3-sample majority filter
// (I2C_SLV_GLITCH_FILTER_EN), SCL edge and START/STOP detection.
module i2c_line_cond (
  input  logic clk_i,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_c, sda_c;
  logic       scl_dly_q, sda_dly_q;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [2:0] scl_win_q, sda_win_q;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // A level must occupy two of the three window slots to pass.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      scl_win_q <= 3'b111;
      sda_win_q <= 3'b111;
    end else begin
      scl_win_q <= {scl_win_q[1:0], scl_sync_q[1]};
      sda_win_q <= {sda_win_q[1:0], sda_sync_q[1]};
    end
  end

  assign scl_c = maj3(scl_win_q);
  assign sda_c = maj3(sda_win_q);
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      scl_dly_q <= 1'b1;
      sda_dly_q <= 1'b1;
    end else begin
      scl_dly_q <= scl_c;
      sda_dly_q <= sda_c;
    end
  end

  assign scl_rise_o = scl_c & ~scl_dly_q;
  assign scl_fall_o = ~scl_c & scl_dly_q;
  assign start_o    = scl_c & scl_dly_q & sda_dly_q & ~sda_c;
  assign stop_o     = scl_c & scl_dly_q & ~sda_dly_q & sda_c;
  assign sda_o      = sda_c;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing a 16-bit register pointer with write/read strobes.
// Define I2C_SLV_GLITCH_FILTER_EN to enable the input majority filter.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
  parameter bit         AUTO_INC = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy,
  output logic        stop_det
);

  localparam logic [BITCNT_W-1:0] BIT8 = BITCNT_W'(8);
  localparam logic [BITCNT_W-1:0] ONE  = BITCNT_W'(1);

  logic                scl_rise, scl_fall, start, stop, sda_s;
  state_e              state_q;
  logic [BITCNT_W-1:0] bitcnt_q;
  logic [7:0]          shift_q, regh_q, wdata_q;
  logic [15:0]         ptr_q, ptr_inc_d;
  logic                rw_q, ack_q, rd_load_q;
  logic                sda_oe_q, we_q, re_q, busy_q, stopdet_q;

  i2c_line_cond u_line (
    .clk_i      (clk_i),
    .rst        (rst),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop),
    .sda_o      (sda_s)
  );

  assign ptr_inc_d = AUTO_INC ? ptr_q + 16'd1 : ptr_q;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      regh_q    <= '0;
      wdata_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      ack_q     <= 1'b0;
      rd_load_q <= 1'b0;
      sda_oe_q  <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      busy_q    <= 1'b0;
      stopdet_q <= 1'b0;
    end else begin
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      stopdet_q <= 1'b0;
      // Read data arrives one cycle after the strobe; capture it for shifting out.
      rd_load_q <= re_q;
      if (rd_load_q) shift_q <= reg_rdata;

      if (stop) begin
        state_q   <= IDLE;
        bitcnt_q  <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        stopdet_q <= 1'b1;
      end else if (start) begin
        state_q  <= DEV;
        bitcnt_q <= '0;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          DEV, REGH, REGL, WDAT: begin
            if (scl_rise) begin
              shift_q  <= {shift_q[6:0], sda_s};
              bitcnt_q <= bitcnt_q + ONE;
            end else if (scl_fall && bitcnt_q == BIT8) begin
              bitcnt_q <= '0;
              sda_oe_q <= 1'b1;
              if (state_q == DEV) begin
                if (shift_q[7:1] == DEV_ADDR) begin
                  state_q <= DEV_ACK;
                  busy_q  <= 1'b1;
                  rw_q    <= shift_q[0];
                end else begin
                  state_q  <= IGNORE;
                  sda_oe_q <= 1'b0;
                end
              end else if (state_q == REGH) begin
                regh_q  <= shift_q;
                state_q <= REGH_ACK;
              end else if (state_q == REGL) begin
                state_q <= REGL_ACK;
              end else begin
                we_q    <= 1'b1;
                wdata_q <= shift_q;
                state_q <= WDAT_ACK;
              end
            end
          end
          DEV_ACK: begin
            if (scl_rise && rw_q) begin
              re_q <= 1'b1;
            end else if (scl_fall) begin
              bitcnt_q <= '0;
              state_q  <= rw_q ? RDAT : REGH;
              sda_oe_q <= rw_q & ~shift_q[7];
            end
          end
          REGH_ACK: if (scl_fall) begin
            state_q  <= REGL;
            sda_oe_q <= 1'b0;
          end
          REGL_ACK: if (scl_fall) begin
            state_q  <= WDAT;
            sda_oe_q <= 1'b0;
            ptr_q    <= {regh_q, shift_q};
          end
          WDAT_ACK: if (scl_fall) begin
            state_q  <= WDAT;
            sda_oe_q <= 1'b0;
            ptr_q    <= ptr_inc_d;
          end
          RDAT: begin
            if (scl_rise) begin
              bitcnt_q <= bitcnt_q + ONE;
            end else if (scl_fall) begin
              if (bitcnt_q == BIT8) begin
                state_q  <= RDAT_ACK;
                sda_oe_q <= 1'b0;
                bitcnt_q <= '0;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end
          RDAT_ACK: begin
            if (scl_rise) begin
              ack_q <= ~sda_s;
              if (!sda_s) begin
                re_q  <= 1'b1;
                ptr_q <= ptr_inc_d;
              end
            end else if (scl_fall) begin
              state_q  <= ack_q ? RDAT : IGNORE;
              sda_oe_q <= ack_q & ~shift_q[7];
            end
          end
          IDLE, IGNORE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = ptr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;
  assign stop_det  = stopdet_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: table of write transactions, directed corner cases
// and randomized traffic checked against a byte-array register model.
module tb_i2c_slave_regs;
  timeunit 1ns;
  timeprecision 1ps;
  import i2c_pkg::*;

  localparam int Q = 10;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        scl_m, sda_m;
  logic        sda_bus;
  logic        sda_oe;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we, reg_re;
  logic [7:0]  rdata;
  logic        busy, stop_det;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regs dut (
    .clk_i     (clk_i),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (rdata),
    .busy      (busy),
    .stop_det  (stop_det)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] we_addr [$];
  logic [7:0]  we_data [$];
  int          re_cnt = 0;
  int          stop_cnt = 0;
  logic        oe_seen = 1'b0;
  logic        busy_seen = 1'b0;

  // Register file attached to the slave, plus event log.
  always @(negedge clk_i) begin
    if (!rst) begin
      if (reg_we) begin
        we_addr.push_back(reg_addr);
        we_data.push_back(reg_wdata);
        mem[reg_addr] = reg_wdata;
      end
      if (reg_re) begin
        re_cnt++;
        rdata = mem[reg_addr];
      end
      if (stop_det) stop_cnt++;
      if (sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    ack = ~sda_bus;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      b[i] = sda_bus;
      wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
    end
    send_bit(~mack);
    sda_m = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  dev;
    int          nb;
    logic [31:0] bytes;
    logic        ack;
    int          nwe;
    logic [15:0] a0;
    logic [7:0]  d0;
    logic [15:0] a1;
    logic [7:0]  d1;
  } wvec_t;

  wvec_t       tv [4];
  logic        ack;
  logic [7:0]  rb;
  logic [15:0] a;
  logic [7:0]  d;
  logic [6:0]  wa;
  int          we0, st0, re0, n, bc0, glitch_exp;

  initial begin
    tv[0] = '{8'h78, 3, 32'h1234A500, 1'b1, 1, 16'h1234, 8'hA5, 16'h0000, 8'h00};
    tv[1] = '{8'h78, 4, 32'hFFFF0102, 1'b1, 2, 16'hFFFF, 8'h01, 16'h0000, 8'h02};
    tv[2] = '{8'h7A, 1, 32'h55000000, 1'b0, 0, 16'h0000, 8'h00, 16'h0000, 8'h00};
    tv[3] = '{8'h78, 4, 32'h00071122, 1'b1, 2, 16'h0007, 8'h11, 16'h0008, 8'h22};
`ifdef I2C_SLV_GLITCH_FILTER_EN
    glitch_exp = 0;
`else
    glitch_exp = 1;
`endif
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'((i * 37) ^ (i >> 8));
      ref_mem[i] = 8'((i * 37) ^ (i >> 8));
    end
    rdata = 8'h00;
    scl_m = 1'b1;
    sda_m = 1'b1;
    rst   = 1'b1;
    wait_clk(5);
    check("rst sda_oe", sda_oe, 0);
    check("rst reg_addr", reg_addr, 0);
    check("rst reg_wdata", reg_wdata, 0);
    check("rst reg_we", reg_we, 0);
    check("rst reg_re", reg_re, 0);
    check("rst busy", busy, 0);
    check("rst stop_det", stop_det, 0);
    check("rst state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    wait_clk(5);

    for (int v = 0; v < 4; v++) begin
      we0 = we_addr.size();
      st0 = stop_cnt;
      oe_seen = 1'b0;
      busy_seen = 1'b0;
      i2c_start();
      send_byte(tv[v].dev, ack);
      check($sformatf("v%0d dev ack", v), ack, tv[v].ack);
      for (int i = 0; i < tv[v].nb; i++) begin
        send_byte(tv[v].bytes[31 - 8 * i -: 8], ack);
        check($sformatf("v%0d byte%0d ack", v, i), ack, tv[v].ack);
      end
      i2c_stop();
      check($sformatf("v%0d writes", v), we_addr.size() - we0, tv[v].nwe);
      if (tv[v].nwe >= 1) begin
        check($sformatf("v%0d addr0", v), we_addr[we0], tv[v].a0);
        check($sformatf("v%0d data0", v), we_data[we0], tv[v].d0);
      end
      if (tv[v].nwe >= 2) begin
        check($sformatf("v%0d addr1", v), we_addr[we0 + 1], tv[v].a1);
        check($sformatf("v%0d data1", v), we_data[we0 + 1], tv[v].d1);
      end
      check($sformatf("v%0d sda_oe seen", v), oe_seen, tv[v].ack);
      check($sformatf("v%0d busy seen", v), busy_seen, tv[v].ack);
      check($sformatf("v%0d busy after stop", v), busy, 0);
      check($sformatf("v%0d stop pulses", v), stop_cnt - st0, 1);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < tv[i].nwe; j++)
        ref_mem[j == 0 ? tv[i].a0 : tv[i].a1] = (j == 0) ? tv[i].d0 : tv[i].d1;

    // Pointer set by a write, repeated START, then a two-byte read.
    mem[16'h0010] = 8'h5A;
    mem[16'h0011] = 8'hC3;
    ref_mem[16'h0010] = 8'h5A;
    ref_mem[16'h0011] = 8'hC3;
    re0 = re_cnt;
    we0 = we_addr.size();
    i2c_start();
    send_byte(8'h78, ack);
    send_byte(8'h00, ack);
    send_byte(8'h10, ack);
    i2c_start();
    send_byte(8'h79, ack);
    check("rd dev ack", ack, 1);
    recv_byte(1'b1, rb);
    check("rd byte0", rb, 8'h5A);
    recv_byte(1'b0, rb);
    check("rd byte1", rb, 8'hC3);
    wait_clk(Q);
    check("rd re pulses", re_cnt - re0, 2);
    check("rd state", 32'(dut.state_q), 32'(IGNORE));
    check("rd pointer", reg_addr, 16'h0011);
    check("rd sda released", sda_oe, 0);
    i2c_stop();
    check("rd no writes", we_addr.size() - we0, 0);

    // STOP in the middle of a data byte.
    we0 = we_addr.size();
    st0 = stop_cnt;
    i2c_start();
    send_byte(8'h78, ack);
    send_byte(8'h00, ack);
    send_byte(8'h20, ack);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    i2c_stop();
    check("abort no we", we_addr.size() - we0, 0);
    check("abort stop pulses", stop_cnt - st0, 1);
    check("abort state", 32'(dut.state_q), 32'(IDLE));
    check("abort busy", busy, 0);

    // Randomized traffic against the reference register array.
    for (int t = 0; t < 9; t++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 2) == 0) a = 16'hFFFE;
      n = $urandom_range(1, 3);
      we0 = we_addr.size();
      re0 = re_cnt;
      if (t % 3 == 0) begin
        i2c_start();
        send_byte(8'h78, ack);
        send_byte(a[15:8], ack);
        send_byte(a[7:0], ack);
        for (int i = 0; i < n; i++) begin
          d = 8'($urandom);
          send_byte(d, ack);
          check($sformatf("rnd%0d wr ack", t), ack, 1);
          ref_mem[16'(a + 16'(i))] = d;
          check($sformatf("rnd%0d wr data%0d", t, i), we_data[we0 + i], d);
          check($sformatf("rnd%0d wr addr%0d", t, i), we_addr[we0 + i], 16'(a + 16'(i)));
        end
        i2c_stop();
        check($sformatf("rnd%0d wr count", t), we_addr.size() - we0, n);
      end else if (t % 3 == 1) begin
        i2c_start();
        send_byte(8'h78, ack);
        send_byte(a[15:8], ack);
        send_byte(a[7:0], ack);
        i2c_start();
        send_byte(8'h79, ack);
        for (int i = 0; i < n; i++) begin
          recv_byte(i < n - 1, rb);
          check($sformatf("rnd%0d rd byte%0d", t, i), rb, ref_mem[16'(a + 16'(i))]);
        end
        i2c_stop();
        check($sformatf("rnd%0d rd re count", t), re_cnt - re0, n);
      end else begin
        wa = 7'($urandom_range(0, 127));
        if (wa == 7'h3C) wa = 7'h3D;
        oe_seen = 1'b0;
        i2c_start();
        send_byte({wa, 1'b0}, ack);
        check($sformatf("rnd%0d foreign ack", t), ack, 0);
        send_byte(8'($urandom), ack);
        i2c_stop();
        check($sformatf("rnd%0d foreign no we", t), we_addr.size() - we0, 0);
        check($sformatf("rnd%0d foreign no oe", t), oe_seen, 0);
      end
    end

    // One-clock SCL glitch while SCL is low mid-byte.
    we0 = we_addr.size();
    i2c_start();
    send_byte(8'h78, ack);
    send_byte(8'h00, ack);
    send_byte(8'h30, ack);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    wait_clk(4);
    bc0 = int'(dut.bitcnt_q);
    scl_m = 1'b1;
    wait_clk(1);
    scl_m = 1'b0;
    wait_clk(12);
    check("glitch bitcnt delta", int'(dut.bitcnt_q) - bc0, glitch_exp);
    i2c_stop();
    check("glitch no we", we_addr.size() - we0, 0);
    check("ptr before async reset", reg_addr, 16'h0030);

    // Reset must act without waiting for a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async reset addr", reg_addr, 16'h0000);
    check("async reset state", 32'(dut.state_q), 32'(IDLE));
    wait_clk(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
